// File: rtl/fpu_result_stage_if.sv
// Issue/result handshake bundle for the FPU result stage.
// master = upstream issuer and downstream consumer, slave = the stage.
interface fpu_result_stage_if #(
    parameter int CNTW = 16
) ();
    logic            issue_valid;
    logic            issue_ready;
    logic [31:0]     f3;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [3:0]      out_flags;
    logic [CNTW-1:0] result_cnt;

    modport master (
        output issue_valid,
        output f3,
        output out_ready,
        input  issue_ready,
        input  out_valid,
        input  out_data,
        input  out_flags,
        input  result_cnt
    );

    modport slave (
        input  issue_valid,
        input  f3,
        input  out_ready,
        output issue_ready,
        output out_valid,
        output out_data,
        output out_flags,
        output result_cnt
    );
endinterface

// File: rtl/fpu_result_stage.sv
// Captures fixed one-cycle-latency FPU results into a credit-checked FIFO.
// Define FPU_RESULT_FLAGS_EN to store {nan, inf, zero, denorm} per entry.
module fpu_result_stage #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input logic clk,
    input logic rst_n,
    fpu_result_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 2;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            in_flight;
    logic [CNTW-1:0] result_cnt;
    logic [31:0]     data_mem [DEPTH];

    logic [OW-1:0]   occ;
    logic            issue;
    logic            capture;
    logic            pop;

    // An in-flight result already owns a slot, so it counts against credit.
    assign occ             = OW'(count) + OW'(in_flight);
    assign bus.issue_ready = occ < OW'(DEPTH);
    assign issue           = bus.issue_valid & bus.issue_ready;
    assign capture         = in_flight;
    assign pop             = bus.out_valid & bus.out_ready;

    assign bus.out_valid  = count != '0;
    assign bus.out_data   = data_mem[rd_ptr];
    assign bus.result_cnt = result_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_flight  <= 1'b0;
            result_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else begin
            in_flight <= issue;
            if (capture) begin
                data_mem[wr_ptr] <= bus.f3;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                result_cnt <= result_cnt + CNTW'(1);
            end
            if (capture && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!capture && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

`ifdef FPU_RESULT_FLAGS_EN
    logic [3:0] flag_mem [DEPTH];

    function automatic logic [3:0] classify(input logic [31:0] v);
        logic exp_ones;
        logic exp_zero;
        logic frac_nz;
        logic [3:0] fl;
        exp_ones = &v[30:23];
        exp_zero = ~|v[30:23];
        frac_nz  = |v[22:0];
        fl       = 4'b0000;
        unique case (1'b1)
            exp_ones &&  frac_nz: fl = 4'b1000;
            exp_ones && !frac_nz: fl = 4'b0100;
            exp_zero && !frac_nz: fl = 4'b0010;
            exp_zero &&  frac_nz: fl = 4'b0001;
            default:              fl = 4'b0000;
        endcase
        return fl;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                flag_mem[i] <= '0;
            end
        end else if (capture) begin
            flag_mem[wr_ptr] <= classify(bus.f3);
        end
    end

    assign bus.out_flags = flag_mem[rd_ptr];
`else
    assign bus.out_flags = 4'b0000;
`endif

endmodule
